// File: rtl/texto_lcd_pkg.sv
// texto_lcd shared definitions: panel timing, text placement,
// colours, the message string and the glyph code set.
package texto_lcd_pkg;

    localparam int H_TOTAL  = 1056;
    localparam int H_PW     = 30;
    localparam int H_BP     = 46;
    localparam int H_ACT    = 800;
    localparam int V_TOTAL  = 525;
    localparam int V_PW     = 13;
    localparam int V_BP     = 23;
    localparam int V_ACT    = 480;
    localparam int TXT_X0   = 288;
    localparam int TXT_Y0   = 232;
    localparam int TXT_LEN  = 14;
    localparam int CELL     = 16;

    localparam logic [23:0] FG = 24'hFFFFFF;
    localparam logic [23:0] BG = 24'h0000FF;

    typedef enum logic [3:0] {
        CH_SP, CH_P, CH_R, CH_O, CH_Y, CH_E,
        CH_C, CH_T, CH_2, CH_S, CH_D
    } char_e;

    // "PROYECTO 2 SDP" in ASCII
    localparam logic [7:0] TXT_STR [0:TXT_LEN-1] = '{
        8'h50, 8'h52, 8'h4F, 8'h59, 8'h45, 8'h43, 8'h54,
        8'h4F, 8'h20, 8'h32, 8'h20, 8'h53, 8'h44, 8'h50
    };

    function automatic char_e to_code(input logic [7:0] c);
        case (c)
            8'h50:   return CH_P;
            8'h52:   return CH_R;
            8'h4F:   return CH_O;
            8'h59:   return CH_Y;
            8'h45:   return CH_E;
            8'h43:   return CH_C;
            8'h54:   return CH_T;
            8'h32:   return CH_2;
            8'h53:   return CH_S;
            8'h44:   return CH_D;
            default: return CH_SP;
        endcase
    endfunction

endpackage

// File: rtl/texto_lcd_if.sv
// Panel-side signal bundle: clock, reset, syncs, enable and RGB.
// The controller drives it as master, the panel is the slave.
interface texto_lcd_if;
    logic       NCLK;
    logic       GREST;
    logic       HD;
    logic       VD;
    logic       DEN;
    logic [7:0] R;
    logic [7:0] G;
    logic [7:0] B;

    modport master (output NCLK, GREST, HD, VD, DEN, R, G, B);
    modport slave  (input  NCLK, GREST, HD, VD, DEN, R, G, B);
endinterface

// File: rtl/texto_lcd_font_rom.sv
// Combinational 8x8 font lookup (IBM PC glyph set subset).
// Returns one glyph row, bit 7 is the leftmost pixel.
module texto_lcd_font_rom
    import texto_lcd_pkg::*;
(
    input  char_e      code,
    input  logic [2:0] row,
    output logic [7:0] bits
);

    logic [63:0] glyph;
    logic [2:0]  r_inv;

    // glyph select, then pick the requested row (row 0 in the top byte)
    always_comb begin
        glyph = 64'h0;
        case (code)
            CH_P:    glyph = 64'hFC66667C6060F000;
            CH_R:    glyph = 64'hFC66667C6C66E600;
            CH_O:    glyph = 64'h386CC6C6C66C3800;
            CH_Y:    glyph = 64'hCCCCCC7830307800;
            CH_E:    glyph = 64'hFE6268786862FE00;
            CH_C:    glyph = 64'h3C66C0C0C0663C00;
            CH_T:    glyph = 64'hFCB4303030307800;
            CH_2:    glyph = 64'h78CC0C3860CCFC00;
            CH_S:    glyph = 64'h78CCE0701CCC7800;
            CH_D:    glyph = 64'hF86C6666666CF800;
            default: glyph = 64'h0;
        endcase
        r_inv = ~row;
        bits  = glyph[{r_inv, 3'b000} +: 8];
    end

endmodule

// File: rtl/texto_lcd.sv
// 800x480 TFT controller: panel clock/reset, sync timing and a
// fixed white-on-blue text line, all from the 50 MHz board clock.
module texto_lcd
    import texto_lcd_pkg::*;
#(
    parameter int HTOT = H_TOTAL,
    parameter int HPW  = H_PW,
    parameter int HBP  = H_BP,
    parameter int HACT = H_ACT,
    parameter int VTOT = V_TOTAL,
    parameter int VPW  = V_PW,
    parameter int VBP  = V_BP,
    parameter int VACT = V_ACT,
    parameter int TX0  = TXT_X0,
    parameter int TY0  = TXT_Y0
) (
    input  logic        CLK,
    input  logic        RST_n,
    texto_lcd_if.master lcd
);

    localparam logic [10:0] H_LAST = 11'(HTOT - 1);
    localparam logic [10:0] H_PWC  = 11'(HPW);
    localparam logic [10:0] H_A0   = 11'(HBP);
    localparam logic [10:0] H_A1   = 11'(HBP + HACT);
    localparam logic [10:0] T_X0   = 11'(TX0);
    localparam logic [10:0] T_X1   = 11'(TX0 + TXT_LEN * CELL);
    localparam logic [9:0]  V_LAST = 10'(VTOT - 1);
    localparam logic [9:0]  V_PWC  = 10'(VPW);
    localparam logic [9:0]  V_A0   = 10'(VBP);
    localparam logic [9:0]  V_A1   = 10'(VBP + VACT);
    localparam logic [9:0]  T_Y0   = 10'(TY0);
    localparam logic [9:0]  T_Y1   = 10'(TY0 + CELL);

    logic        nclk;
    logic        grest;
    logic [10:0] hcnt;
    logic [9:0]  vcnt;
    logic        hd, vd, den;
    logic [23:0] rgb;

    logic        hd_n, vd_n, den_n, in_txt, pix_on;
    logic [23:0] rgb_n;
    logic [10:0] x;
    logic [9:0]  y;
    logic [7:0]  tx;
    logic [3:0]  ty;
    logic [3:0]  idx;
    char_e       code;
    logic [7:0]  bits;
    logic        unused_bits;

    // panel clock is CLK/2 starting low; GREST rises on the first edge
    always_ff @(posedge CLK or posedge RST_n) begin
        if (RST_n) begin
            nclk  <= 1'b0;
            grest <= 1'b0;
        end else begin
            nclk  <= ~nclk;
            grest <= 1'b1;
        end
    end

    // raster counters step when NCLK falls
    always_ff @(posedge CLK or posedge RST_n) begin
        if (RST_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (nclk) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
            end else begin
                hcnt <= hcnt + 11'd1;
            end
        end
    end

    // only the low bits of the text offsets matter (modulo arithmetic)
    assign x  = hcnt - H_A0;
    assign y  = vcnt - V_A0;
    assign tx = x[7:0] - T_X0[7:0];
    assign ty = y[3:0] - T_Y0[3:0];
    assign unused_bits = ^{tx[0], ty[0]};

    assign idx  = in_txt ? tx[7:4] : 4'd0;
    assign code = to_code(TXT_STR[idx]);

    texto_lcd_font_rom u_font (
        .code (code),
        .row  (ty[3:1]),
        .bits (bits)
    );

    // sync/enable decode and pixel colour for the current counters
    always_comb begin
        hd_n   = ~(hcnt < H_PWC);
        vd_n   = ~(vcnt < V_PWC);
        den_n  = (hcnt >= H_A0) && (hcnt < H_A1) &&
                 (vcnt >= V_A0) && (vcnt < V_A1);
        in_txt = (x >= T_X0) && (x < T_X1) &&
                 (y >= T_Y0) && (y < T_Y1);
        pix_on = in_txt && bits[~tx[3:1]];
        rgb_n  = 24'h0;
        if (den_n) begin
            rgb_n = pix_on ? FG : BG;
        end
    end

    // output register, loaded together with the counter step
    always_ff @(posedge CLK or posedge RST_n) begin
        if (RST_n) begin
            hd  <= 1'b1;
            vd  <= 1'b1;
            den <= 1'b0;
            rgb <= 24'h0;
        end else if (nclk) begin
            hd  <= hd_n;
            vd  <= vd_n;
            den <= den_n;
            rgb <= rgb_n;
        end
    end

    assign lcd.NCLK  = nclk;
    assign lcd.GREST = grest;
    assign lcd.HD    = hd;
    assign lcd.VD    = vd;
    assign lcd.DEN   = den;
    assign lcd.R     = rgb[23:16];
    assign lcd.G     = rgb[15:8];
    assign lcd.B     = rgb[7:0];

endmodule

// File: tb/tb_texto_lcd.sv
// Directed bench for texto_lcd with a shortened vertical frame
// (28 lines, text at y=2) so a whole frame fits a short run.
`timescale 1ns/1ps
module tb_texto_lcd;

    localparam int HT = 1056;
    localparam int VT = 28;
    localparam int VP = 3;
    localparam int VB = 6;
    localparam int VA = 20;
    localparam int TY = 2;
    localparam int FRAME = HT * VT;

    localparam logic [24:0] FG1 = {1'b1, 24'hFFFFFF};
    localparam logic [24:0] BG1 = {1'b1, 24'h0000FF};
    localparam logic [24:0] BLK = 25'h0;
    localparam logic [28:0] RSTV = {5'b00110, 24'h0};

    localparam int NS = 25;
    localparam int SK [0:NS-1] = '{
        0, 6381, 6382, 7181, 7182, 27245, 27556, 8782, 8794,
        25678, 7726, 9838, 21470, 21476, 11022, 8928, 8926,
        11114, 9006, 13200, 15300, 17282, 10994, 13088, 8818
    };
    localparam logic [24:0] SE [0:NS-1] = '{
        BLK, BLK, BG1, BG1, BLK, BG1, BLK, FG1, BG1,
        BG1, BG1, FG1, FG1, BG1, BG1, FG1, BG1,
        FG1, BG1, FG1, FG1, FG1, FG1, FG1, FG1
    };

    logic CLK = 1'b0;
    logic RST_n = 1'b1;

    texto_lcd_if lcd ();

    texto_lcd #(
        .VTOT (VT),
        .VPW  (VP),
        .VBP  (VB),
        .VACT (VA),
        .TY0  (TY)
    ) dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .lcd   (lcd)
    );

    always #10 CLK = ~CLK;

    logic [28:0] ov;
    assign ov = {lcd.NCLK, lcd.GREST, lcd.HD, lcd.VD, lcd.DEN,
                 lcd.R, lcd.G, lcd.B};

    int errs = 0;
    int checks = 0;
    int tmo = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_pix();
        bit found = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (lcd.NCLK == 1'b0) begin
                found = 1;
                break;
            end
        end
        if (!found) tmo++;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        int hd_f [2];
        int vd_f [2];
        int nhf, nvf, hd_low0, den6, den6_first, den6_last;
        int den_lines, den_line0, den_vd_bad, vd_low;
        bit line_den;
        logic prev_hd, prev_vd;
        longint t0, t1;

        repeat (20) begin
            @(negedge CLK);
            check("rst_init", ov, RSTV);
        end

        RST_n = 1'b0;
        @(negedge CLK);
        check("rel0", {lcd.NCLK, lcd.GREST, lcd.HD, lcd.VD}, 4'b1111);

        for (int k = 0; k <= 6736; k++) next_pix();
        check("pre_rst", ov[24:0], BG1);

        RST_n = 1'b1;
        #1;
        check("rst_async", ov, RSTV);
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        check("rst_hold", ov, RSTV);

        RST_n = 1'b0;
        @(negedge CLK);
        check("rel1", {lcd.NCLK, lcd.GREST, lcd.HD, lcd.VD}, 4'b1111);

        nhf = 0; nvf = 0; hd_low0 = 0; den6 = 0;
        den6_first = -1; den6_last = -1;
        den_lines = 0; den_line0 = -1; den_vd_bad = 0; vd_low = 0;
        hd_f = '{-1, -1}; vd_f = '{-1, -1};
        line_den = 0; prev_hd = 1'b1; prev_vd = 1'b1;
        t0 = 0; t1 = 0;

        for (int k = 0; k <= FRAME; k++) begin
            int v, h;
            next_pix();
            v = k / HT;
            h = k % HT;
            if (k == 0) t0 = $time;
            if (k == 1000) t1 = $time;
            for (int j = 0; j < NS; j++)
                if (SK[j] == k) check($sformatf("pix_k%0d", k), ov[24:0], SE[j]);
            if (prev_hd && !lcd.HD && nhf < 2) begin
                hd_f[nhf] = k; nhf++;
            end
            if (prev_vd && !lcd.VD && nvf < 2) begin
                vd_f[nvf] = k; nvf++;
            end
            prev_hd = lcd.HD;
            prev_vd = lcd.VD;
            if (k < HT && !lcd.HD) hd_low0++;
            if (k < FRAME) begin
                if (!lcd.VD) vd_low++;
                if (lcd.DEN && !lcd.VD) den_vd_bad++;
                if (lcd.DEN) line_den = 1;
                if (v == VB && lcd.DEN) begin
                    den6++;
                    if (den6_first < 0) den6_first = k;
                    den6_last = k;
                end
                if (h == HT - 1) begin
                    if (line_den) begin
                        den_lines++;
                        if (den_line0 < 0) den_line0 = v;
                    end
                    line_den = 0;
                end
            end
        end

        check("nclk_period", 32'(t1 - t0), 32'd40000);
        check("hd_fall0", hd_f[0], 0);
        check("hd_fall1", hd_f[1], HT);
        check("hd_low", hd_low0, 30);
        check("den_start", den6_first, VB * HT + 46);
        check("den_len", den6, 800);
        check("den_end", den6_last, VB * HT + 845);
        check("den_lines", den_lines, VA);
        check("den_line0", den_line0, VB);
        check("den_in_vd", den_vd_bad, 0);
        check("vd_low", vd_low, VP * HT);
        check("vd_fall0", vd_f[0], 0);
        check("vd_fall1", vd_f[1], FRAME);
        check("pix_timeout", tmo, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
